// File: rtl/mix_pkg.sv
// Shared types and defaults for the iterative lane-mixing engine.
// The idx() helper wraps lane offsets around the lane count.
package mix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_LANES      = 8;
  localparam int DEF_MAX_ROUNDS = 8;
  localparam int DEF_SHL        = 16;
  localparam int DEF_SHR_A      = 17;
  localparam int DEF_SHR_B      = 12;

  function automatic int idx(input int i, input int off, input int lanes);
    return (i + off) % lanes;
  endfunction

endpackage

// File: rtl/mix_round.sv
// One full mixing round (passes A, B, C), purely combinational.
// Lanes update in ascending order and each update sees the already-updated lower lanes.
module mix_round
  import mix_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int SHL   = DEF_SHL,
  parameter int SHR_A = DEF_SHR_A,
  parameter int SHR_B = DEF_SHR_B
) (
  input  logic [LANES*WIDTH-1:0] state_i,
  output logic [LANES*WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] o [LANES];

  // Blocking updates inside one block give the chained lane semantics directly.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      o[i] = state_i[i*WIDTH +: WIDTH];
    end
    for (int i = 0; i < LANES; i++) begin
      o[i] = o[i] + o[idx(i, 1, LANES)] - o[idx(i, LANES - 3, LANES)];
    end
    for (int i = 0; i < LANES; i++) begin
      o[i] = o[i] ^ (o[idx(i, 3, LANES)] << SHL);
    end
    for (int i = 0; i < LANES; i++) begin
      o[i] = o[i] - (o[idx(i, 2, LANES)] >> SHR_A) + (o[idx(i, 4, LANES)] >> SHR_B);
    end
    state_o = '0;
    for (int i = 0; i < LANES; i++) begin
      state_o[i*WIDTH +: WIDTH] = o[i];
    end
  end

endmodule

// File: rtl/mix_engine.sv
// Job-based mixing engine: accepts a seed, runs N rounds (one per clock), then holds
// the result until it is consumed. flush aborts any job without touching the lanes.
module mix_engine
  import mix_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
  parameter int SHL        = DEF_SHL,
  parameter int SHR_A      = DEF_SHR_A,
  parameter int SHR_B      = DEF_SHR_B,
  localparam int RW        = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [RW-1:0]          in_rounds,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   busy
);

  localparam logic [RW-1:0] MAX_R = RW'(MAX_ROUNDS);

  fsm_t                   state_q, state_d;
  logic [LANES*WIDTH-1:0] lanes_q, lanes_d;
  logic [RW-1:0]          cnt_q, cnt_d;
  logic [LANES*WIDTH-1:0] round_out;
  logic [RW-1:0]          n_clamped;

  assign n_clamped = (in_rounds > MAX_R) ? MAX_R : in_rounds;

  mix_round #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .SHL  (SHL),
    .SHR_A(SHR_A),
    .SHR_B(SHR_B)
  ) u_round (
    .state_i(lanes_q),
    .state_o(round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lanes_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
    end
  end

  // flush wins over everything and leaves the lane registers untouched.
  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            lanes_d = in_data;
            if (n_clamped == '0) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              state_d = RUN;
              cnt_d   = n_clamped - RW'(1);
            end
          end
        end
        RUN: begin
          lanes_d = round_out;
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - RW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !flush;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = lanes_q;
  end

endmodule
